serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: Start  input  1  request to begin an addition; sampled on the rising edge of Clk.
REQ-005 Port: A  input  WIDTH  first operand; captured only when Start is accepted.
REQ-006 Port: B  input  WIDTH  second operand; captured only when Start is accepted.
REQ-007 Port: Cin  input  1  carry-in; captured only when Start is accepted.
REQ-008 Port: Busy  output  1  high while an addition is in progress.
REQ-009 Port: Done  output  1  one-cycle pulse marking a valid result.
REQ-010 Port: Sum  output  WIDTH  result of A+B+Cin, modulo 2^WIDTH.
REQ-011 Port: Cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-013 In IDLE with Start=1 at an edge, the block SHALL capture A, B and Cin into internal shift and carry registers, load a bit counter with 0, and enter ADD.
REQ-014 In ADD, each edge SHALL process exactly one bit, LSB first, using full-adder equations:
- s = a^b^c
- c' = (a&b)|(b&c)|(c&a)
- c' SHALL be stored in the carry flip-flop.
- s SHALL be shifted into the MSB of an internal result shift register.
- Both operand registers SHALL shift right by one.
- The counter SHALL increment.
REQ-015 After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE. At that same edge, Sum SHALL load the completed result register and Cout SHALL load the final carry.
REQ-016 Latency: with Start accepted at edge t0, Done SHALL be high during the cycle between edges t0+WIDTH and t0+WIDTH+1, and Busy SHALL be high from edge t0 until edge t0+WIDTH.
REQ-017 In DONE, the FSM SHALL return to IDLE at the next edge; with Start=1 at that edge, it SHALL instead capture new operands and enter ADD (back-to-back operation).
REQ-018 Sum and Cout SHALL change only at the completion edge of REQ-015; they SHALL hold their value through IDLE and through any later ADD until the next completion.
REQ-019 Start while in ADD SHALL be ignored:
- no operand capture;
- no effect on the operation in progress or on its latency.
REQ-020 Changes on A, B or Cin outside the accepting edge SHALL have no effect.
REQ-021 Busy and Done SHALL be registered outputs and SHALL never be high together.
REQ-022 Arithmetic SHALL be unsigned. Overflow SHALL be reported only through Cout, with no saturation.

Reset
REQ-023 Rst_n=0 SHALL immediately, without waiting for Clk:
- force the FSM to IDLE;
- set Busy=0, Done=0, Sum=0, Cout=0;
- clear the counter, the carry flip-flop and all shift registers.
REQ-024 Reset during ADD SHALL abort the operation. No Done pulse SHALL follow, and Sum and Cout SHALL remain 0.
REQ-025 Start SHALL be ignored at any edge where Rst_n=0. The first edge after Rst_n deasserts SHALL accept Start normally.

Verification (WIDTH=8)
REQ-026 A=0x5A, B=0x3C, Cin=0, Start at edge t0 -> Sum=0x96, Cout=0, Done high only in cycle t0+8, Busy high for exactly 8 cycles.
REQ-027 A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
REQ-028 Start=1 held for 3 cycles with A=0x01, B=0x01; operands changed to 0x10 during ADD -> exactly one Done, with Sum=0x02.
REQ-029 Start at edge t0 with 0x0F+0x01, then Start during Done with 0x80+0x80 -> first Done gives Sum=0x10, Cout=0; second Done at t0+17 gives Sum=0x00, Cout=1.
REQ-030 Rst_n pulled low after 4 ADD cycles -> Busy, Done, Sum and Cout go to 0 asynchronously, no Done follows, and the next Start completes correctly.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: captures A, B and Cin on an accepted Start,
// then resolves one bit per clock, LSB first, through a single full adder.
// The result is published on Sum/Cout together with a one-cycle Done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             bit_c;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Full-adder carry bit (majority of the three inputs).
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (c & a);
  endfunction

  // Next-state logic: operand capture, per-bit adder step and completion.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    bit_s = fa_sum(a_q[0], b_q[0], c_q);
    bit_c = fa_carry(a_q[0], b_q[0], c_q);

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end

      ADD: begin
        // Start is deliberately ignored here; the operation runs to completion.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = bit_c;
        r_d   = {bit_s, r_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {bit_s, r_q[WIDTH-1:1]};
          cout_d  = bit_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        // A Start arriving during the Done cycle begins the next addition
        // immediately, so back-to-back operations lose no cycle.
        if (Start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             Clk;
  logic             Rst_n;
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full addition: Start for a single edge, operands scrambled right
  // after acceptance, outputs observed for WIDTH+2 cycles after the accept.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es, input logic ec);
    int         busy_n  = 0;
    int         done_n  = 0;
    int         done_at = -1;
    int         both    = 0;
    logic [7:0] s_at    = '0;
    logic       c_at    = 1'b0;
    @(negedge Clk);
    A = a; B = b; Cin = cin; Start = 1'b1;
    for (int k = 0; k <= WIDTH + 1; k++) begin
      @(posedge Clk);
      #1;
      if (k == 0) begin
        Start = 1'b0;
        A = ~a; B = ~b; Cin = ~cin;
      end
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        done_at = k;
        s_at = Sum;
        c_at = Cout;
      end
      if (Busy && Done) both++;
    end
    check_eq({tag, " busy_cycles"}, busy_n, WIDTH);
    check_eq({tag, " done_count"}, done_n, 1);
    check_eq({tag, " done_latency"}, done_at, WIDTH);
    check_eq({tag, " busy_done_overlap"}, both, 0);
    check_eq({tag, " sum"}, s_at, es);
    check_eq({tag, " cout"}, c_at, ec);
  endtask

  initial begin
    int done_n;
    logic [7:0] s_seen;

    n_checks = 0;
    n_fail   = 0;
    Rst_n = 1'b0;
    Start = 1'b0;
    A = '0; B = '0; Cin = 1'b0;

    // Reset state
    #1;
    check_eq("rst busy", Busy, 0);
    check_eq("rst done", Done, 0);
    check_eq("rst sum", Sum, 0);
    check_eq("rst cout", Cout, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Basic additions, including overflow and carry-in corner cases
    run_add("v5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_add("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_add("vffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_add("v0000c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    check_eq("hold sum idle", Sum, 8'h01);

    // Start held for 3 cycles, operands changed while adding
    done_n = 0;
    s_seen = '0;
    @(negedge Clk);
    A = 8'h01; B = 8'h01; Cin = 1'b0; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    A = 8'h10; B = 8'h10;
    @(posedge Clk);
    @(negedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 3; k <= 14; k++) begin
      @(posedge Clk);
      #1;
      if (Done) begin
        done_n++;
        s_seen = Sum;
      end
    end
    check_eq("held_start done_count", done_n, 1);
    check_eq("held_start sum", s_seen, 8'h02);

    // Back-to-back: second Start presented during the Done cycle
    @(negedge Clk);
    A = 8'h0F; B = 8'h01; Cin = 1'b0; Start = 1'b1;
    @(posedge Clk);                       // t0
    @(negedge Clk);
    Start = 1'b0;
    repeat (WIDTH) @(posedge Clk);        // t0+8
    #1;
    check_eq("b2b first done", Done, 1);
    check_eq("b2b first sum", Sum, 8'h10);
    check_eq("b2b first cout", Cout, 0);
    @(negedge Clk);
    A = 8'h80; B = 8'h80; Cin = 1'b0; Start = 1'b1;
    @(posedge Clk);                       // t0+9
    #1;
    check_eq("b2b restart busy", Busy, 1);
    check_eq("b2b restart done", Done, 0);
    check_eq("b2b hold sum", Sum, 8'h10);
    @(negedge Clk);
    Start = 1'b0;
    repeat (WIDTH - 1) @(posedge Clk);    // t0+16
    #1;
    check_eq("b2b pre done", Done, 0);
    @(posedge Clk);                       // t0+17
    #1;
    check_eq("b2b second done", Done, 1);
    check_eq("b2b second sum", Sum, 8'h00);
    check_eq("b2b second cout", Cout, 1);

    // Asynchronous reset in the middle of an addition
    @(negedge Clk);
    A = 8'hAA; B = 8'h55; Cin = 1'b1; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check_eq("pre_abort busy", Busy, 1);
    Rst_n = 1'b0;
    #1;
    check_eq("abort busy", Busy, 0);
    check_eq("abort done", Done, 0);
    check_eq("abort sum", Sum, 0);
    check_eq("abort cout", Cout, 0);
    A = 8'h12; B = 8'h34; Cin = 1'b1; Start = 1'b1;
    done_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      #1;
      if (Done || Busy) done_n++;
    end
    check_eq("start_in_reset ignored", done_n, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    Start = 1'b0;
    run_add("after_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
